// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default payload width, bubble encodings and
// the packed payload struct carried by each inter-stage register.
package pipeline_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // addi x0, x0, 0 -- the canonical RISC-V NOP
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    // Bubble payloads: the IF/ID bubble carries a real NOP so decode sees a
    // harmless instruction; later stages only need their write enables low.
    localparam if_id_t  IF_ID_FLUSH  = '{pc: '0, instr: NOP_INSTR};
    localparam id_ex_t  ID_EX_FLUSH  = '0;
    localparam ex_mem_t EX_MEM_FLUSH = '0;
    localparam mem_wb_t MEM_WB_FLUSH = '0;

endpackage

// File: rtl/pipeline_reg_if.sv
// Handshake/payload bundle between an upstream stage and a pipeline register.
interface pipeline_reg_if #(
    parameter int unsigned WIDTH = 32
);
    logic             flush_i;
    logic             stall_i;
    logic             valid_i;
    logic [WIDTH-1:0] data_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;

    // Hazard/upstream side: drives controls and payload, sees the register.
    modport master (
        output flush_i, stall_i, valid_i, data_i,
        input  valid_o, data_o
    );

    // Register side.
    modport slave (
        input  flush_i, stall_i, valid_i, data_i,
        output valid_o, data_o
    );
endinterface

// File: rtl/pipeline_reg.sv
// Pipeline stage register with stall (hold) and flush (bubble insert).
// Priority per edge: reset, flush, stall, load.
module pipeline_reg
    import pipeline_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_reg_if.slave    bus
);

    // Payload and valid flops; stall simply leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_o  <= RESET_VALUE;
            bus.valid_o <= 1'b0;
        end else if (bus.flush_i) begin
            bus.data_o  <= FLUSH_VALUE;
            bus.valid_o <= 1'b0;
        end else if (!bus.stall_i) begin
            bus.data_o  <= bus.data_i;
            bus.valid_o <= bus.valid_i;
        end
    end

endmodule

// File: tb/tb_pipeline_reg.sv
// Self-checking bench for pipeline_reg: directed steps on a 32-bit default
// instance and an 8-bit instance with a non-zero flush value, then a random
// run against a behavioural model of the stage register.
module tb_pipeline_reg;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst8;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_reg_if #(.WIDTH(32)) b32 ();
    pipeline_reg_if #(.WIDTH(8))  b8 ();

    pipeline_reg #(
        .WIDTH(32)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(b32)
    );

    pipeline_reg #(
        .WIDTH(8),
        .RESET_VALUE(8'h00),
        .FLUSH_VALUE(8'h13)
    ) u_dut8 (
        .clk(clk),
        .rst(rst8),
        .bus(b8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input logic f, input logic s, input logic v, input logic [31:0] d);
        b32.flush_i = f;
        b32.stall_i = s;
        b32.valid_i = v;
        b32.data_i  = d;
    endtask

    task automatic drive8(input logic f, input logic s, input logic v, input logic [7:0] d);
        b8.flush_i = f;
        b8.stall_i = s;
        b8.valid_i = v;
        b8.data_i  = d;
    endtask

    // Behavioural model state for the random run.
    logic [31:0] m_data;
    logic        m_valid;

    initial begin
        logic        r, f, s, v;
        logic [31:0] d;

        rst  = 1'b0;
        rst8 = 1'b0;
        drive32(1'b0, 1'b0, 1'b0, 32'h0);
        drive8(1'b0, 1'b0, 1'b0, 8'h0);
        #2;

        // Reset with live-looking input must be ignored in favour of reset.
        rst = 1'b1;
        drive32(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        check("reset_data", 64'(b32.data_o), 64'h0);
        check("reset_valid", 64'(b32.valid_o), 64'h0);
        tick();
        check("reset_hold_data", 64'(b32.data_o), 64'h0);
        check("reset_hold_valid", 64'(b32.valid_o), 64'h0);

        // Load.
        rst = 1'b0;
        drive32(1'b0, 1'b0, 1'b1, 32'hCAFE_BABE);
        tick();
        check("load_data", 64'(b32.data_o), 64'hCAFE_BABE);
        check("load_valid", 64'(b32.valid_o), 64'h1);

        // Output is registered: a mid-cycle input change does not propagate.
        drive32(1'b0, 1'b0, 1'b0, 32'h5555_AAAA);
        #2;
        check("no_comb_path_data", 64'(b32.data_o), 64'hCAFE_BABE);
        check("no_comb_path_valid", 64'(b32.valid_o), 64'h1);

        // Stall for three edges, then release.
        drive32(1'b0, 1'b1, 1'b0, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_data_%0d", i), 64'(b32.data_o), 64'hCAFE_BABE);
            check($sformatf("stall_valid_%0d", i), 64'(b32.valid_o), 64'h1);
        end
        drive32(1'b0, 1'b0, 1'b1, 32'h1234_5678);
        tick();
        check("unstall_data", 64'(b32.data_o), 64'h1234_5678);
        check("unstall_valid", 64'(b32.valid_o), 64'h1);

        // Flush.
        drive32(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        tick();
        check("flush_data", 64'(b32.data_o), 64'h0);
        check("flush_valid", 64'(b32.valid_o), 64'h0);

        // Flush beats stall.
        drive32(1'b0, 1'b0, 1'b1, 32'h1111_2222);
        tick();
        check("preload_data", 64'(b32.data_o), 64'h1111_2222);
        drive32(1'b1, 1'b1, 1'b1, 32'hAAAA_BBBB);
        tick();
        check("flush_stall_data", 64'(b32.data_o), 64'h0);
        check("flush_stall_valid", 64'(b32.valid_o), 64'h0);

        // Load with valid low carries the valid bit through.
        drive32(1'b0, 1'b0, 1'b0, 32'h0BAD_F00D);
        tick();
        check("load_invalid_data", 64'(b32.data_o), 64'h0BAD_F00D);
        check("load_invalid_valid", 64'(b32.valid_o), 64'h0);

        // 8-bit instance with non-default flush value.
        rst8 = 1'b1;
        drive8(1'b0, 1'b0, 1'b1, 8'hA5);
        tick();
        check("w8_reset_data", 64'(b8.data_o), 64'h00);
        check("w8_reset_valid", 64'(b8.valid_o), 64'h0);
        rst8 = 1'b0;
        drive8(1'b0, 1'b0, 1'b1, 8'h5A);
        tick();
        check("w8_load_data", 64'(b8.data_o), 64'h5A);
        check("w8_load_valid", 64'(b8.valid_o), 64'h1);
        drive8(1'b1, 1'b0, 1'b1, 8'hFF);
        tick();
        check("w8_flush_data", 64'(b8.data_o), 64'h13);
        check("w8_flush_valid", 64'(b8.valid_o), 64'h0);
        drive8(1'b0, 1'b0, 1'b1, 8'h77);
        tick();
        check("w8_reload_data", 64'(b8.data_o), 64'h77);
        drive8(1'b1, 1'b1, 1'b1, 8'h66);
        tick();
        check("w8_flush_stall_data", 64'(b8.data_o), 64'h13);
        drive8(1'b0, 1'b0, 1'b1, 8'h44);
        tick();
        rst8 = 1'b1;
        drive8(1'b1, 1'b0, 1'b1, 8'h99);
        tick();
        check("w8_reset_flush_data", 64'(b8.data_o), 64'h00);
        check("w8_reset_flush_valid", 64'(b8.valid_o), 64'h0);
        rst8 = 1'b0;
        drive8(1'b0, 1'b1, 1'b1, 8'h21);
        tick();
        check("w8_stall_after_reset_data", 64'(b8.data_o), 64'h00);

        // Random run: model the stage as "what the register holds after the
        // highest-priority action of this edge".
        m_data  = b32.data_o;
        m_valid = b32.valid_o;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 15) == 0);
            f = ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 2) == 0);
            v = 1'($urandom_range(0, 1));
            d = $urandom;
            rst = r;
            drive32(f, s, v, d);
            tick();
            if (r || f) begin
                m_data  = 32'h0;
                m_valid = 1'b0;
            end else if (!s) begin
                m_data  = d;
                m_valid = v;
            end
            check($sformatf("rand_data_%0d", n), 64'(b32.data_o), 64'(m_data));
            check($sformatf("rand_valid_%0d", n), 64'(b32.valid_o), 64'(m_valid));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
